// File: rtl/demux_sel_sequencer.sv
// Channel-select sequencer for the 1:4 demux: steps sel through up, down,
// ping-pong or request-driven round-robin schedules, holding each channel
// for dwell+1 cycles while enabled.
module demux_sel_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         req,
  output logic [1:0]         sel,
  output logic [3:0]         ch_oh,
  output logic               busy,
  output logic               wrap
);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_RR   = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic               dir;

  logic [1:0] nxt_sel_c;
  logic       nxt_wrap_c;
  logic       nxt_dir_c;
  logic       rr_hit_c;
  logic [1:0] rr_idx_c;
  logic       advance_c;

  assign advance_c = (cnt >= dwell);

  // Next channel, wrap flag and ping-pong direction for the current mode
  always_comb begin
    nxt_sel_c  = sel;
    nxt_wrap_c = 1'b0;
    nxt_dir_c  = DIR_UP;
    rr_hit_c   = 1'b0;
    rr_idx_c   = sel;
    case (mode)
      MODE_UP: begin
        nxt_sel_c  = sel + 2'd1;
        nxt_wrap_c = (sel == 2'd3);
      end
      MODE_DOWN: begin
        nxt_sel_c  = sel - 2'd1;
        nxt_wrap_c = (sel == 2'd0);
      end
      MODE_PP: begin
        if (dir == DIR_UP) begin
          if (sel == 2'd3) begin
            nxt_sel_c = 2'd2;
            nxt_dir_c = DIR_DOWN;
          end else begin
            nxt_sel_c = sel + 2'd1;
            nxt_dir_c = DIR_UP;
          end
        end else begin
          if (sel == 2'd0) begin
            nxt_sel_c = 2'd1;
            nxt_dir_c = DIR_UP;
          end else begin
            nxt_sel_c = sel - 2'd1;
            nxt_dir_c = DIR_DOWN;
          end
          nxt_wrap_c = (sel == 2'd1);
        end
      end
      MODE_RR: begin
        // Search sel+1, sel+2, sel+3 and finally sel itself
        for (int i = 1; i <= 4; i++) begin
          rr_idx_c = sel + 2'(i);
          if (!rr_hit_c && req[rr_idx_c]) begin
            rr_hit_c  = 1'b1;
            nxt_sel_c = rr_idx_c;
          end
        end
        nxt_wrap_c = rr_hit_c && (nxt_sel_c <= sel);
      end
      default: begin
        nxt_sel_c = sel;
      end
    endcase
  end

  // Run/idle state machine with dwell counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 2'd0;
      cnt   <= '0;
      dir   <= DIR_UP;
      busy  <= 1'b0;
      wrap  <= 1'b0;
      ch_oh <= 4'b0000;
    end else begin
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          dir <= DIR_UP;
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
            ch_oh <= 4'b0001 << sel;
          end else begin
            busy  <= 1'b0;
            ch_oh <= 4'b0000;
          end
        end
        RUN: begin
          if (!en) begin
            // Dropping enable wins over a pending advance
            state <= IDLE;
            busy  <= 1'b0;
            ch_oh <= 4'b0000;
            cnt   <= '0;
            dir   <= DIR_UP;
          end else if (advance_c) begin
            sel   <= nxt_sel_c;
            cnt   <= '0;
            wrap  <= nxt_wrap_c;
            dir   <= nxt_dir_c;
            ch_oh <= 4'b0001 << nxt_sel_c;
          end else begin
            cnt   <= cnt + DWELL_W'(1);
            ch_oh <= 4'b0001 << sel;
            if (mode != MODE_PP) begin
              dir <= DIR_UP;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Self-checking bench for demux_sel_sequencer: directed vector table,
// hand-written corner sequences and randomized traffic against a
// schedule-level reference model.
module tb_demux_sel_sequencer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] dwell;
  logic [3:0] req;
  logic [1:0] sel;
  logic [3:0] ch_oh;
  logic       busy;
  logic       wrap;

  int n_checks = 0;
  int n_err    = 0;

  demux_sel_sequencer #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .dwell (dwell),
    .req   (req),
    .sel   (sel),
    .ch_oh (ch_oh),
    .busy  (busy),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ping-pong is a position on the 6-step tour 0,1,2,3,2,1
  int pp_tour [6] = '{0, 1, 2, 3, 2, 1};
  bit m_run;
  int m_sel;
  int m_cnt;
  int m_pos;
  bit m_wrap;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [7:0] dwell;
    logic [3:0] req;
    logic [1:0] sel;
    logic       busy;
    logic       wrap;
    logic [3:0] ch_oh;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic e, logic [1:0] md, logic [7:0] dw,
                              logic [1:0] s, logic b, logic w, logic [3:0] oh);
    vec_t v;
    v.en = e; v.mode = md; v.dwell = dw; v.req = 4'b0000;
    v.sel = s; v.busy = b; v.wrap = w; v.ch_oh = oh;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_sel = 0; m_cnt = 0; m_pos = 0; m_wrap = 0;
  endtask

  task automatic model_edge(bit e, int md, int dw, logic [3:0] rq);
    int g;
    m_wrap = 0;
    if (!m_run) begin
      m_cnt = 0;
      m_pos = m_sel;
      m_run = e;
    end else if (!e) begin
      m_run = 0;
      m_cnt = 0;
      m_pos = m_sel;
    end else if (m_cnt >= dw) begin
      m_cnt = 0;
      case (md)
        0: begin m_wrap = (m_sel == 3); m_sel = (m_sel + 1) % 4; end
        1: begin m_wrap = (m_sel == 0); m_sel = (m_sel + 3) % 4; end
        2: begin
          m_pos  = (m_pos + 1) % 6;
          m_wrap = (m_pos == 0);
          m_sel  = pp_tour[m_pos];
        end
        default: begin
          g = -1;
          for (int i = 1; i <= 4; i++)
            if (g < 0 && rq[(m_sel + i) % 4]) g = (m_sel + i) % 4;
          if (g >= 0) begin
            m_wrap = (g <= m_sel);
            m_sel  = g;
          end
        end
      endcase
      if (md != 2) m_pos = m_sel;
    end else begin
      m_cnt++;
      if (md != 2) m_pos = m_sel;
    end
  endtask

  task automatic compare_model(string tag);
    chk({tag, ".sel"},   8'(sel),   8'(m_sel));
    chk({tag, ".busy"},  8'(busy),  8'(m_run));
    chk({tag, ".wrap"},  8'(wrap),  8'(m_wrap));
    chk({tag, ".ch_oh"}, 8'(ch_oh), m_run ? 8'(8'd1 << m_sel) : 8'd0);
  endtask

  // One clock: model follows the applied inputs, DUT sampled 1 ns later
  task automatic step(string tag);
    @(posedge clk);
    model_edge(en, int'(mode), int'(dwell), req);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
  endtask

  initial begin : main
    logic [1:0] pp_sel [8];
    logic       pp_wrp [8];
    logic [1:0] rr_sel [13];
    logic       rr_wrp [13];
    logic [3:0] rr_req [13];

    rst_n = 1'b0; en = 1'b0; mode = 2'd0; dwell = 8'd0; req = 4'b0000;
    model_reset();

    // Reset state held for a couple of edges
    repeat (2) @(posedge clk);
    #1;
    compare_model("reset");
    rst_n = 1'b1;

    // Idle with enable low
    for (int i = 0; i < 20; i++) begin
      step("idle");
      chk("idle.sel_zero", 8'(sel), 8'd0);
    end

    // Directed table: up mode dwell=2, then down mode dwell=0
    vecs.push_back(mk(1, 2'd0, 8'd2, 2'd0, 1, 0, 4'b0001));
    vecs.push_back(mk(1, 2'd0, 8'd2, 2'd0, 1, 0, 4'b0001));
    vecs.push_back(mk(1, 2'd0, 8'd2, 2'd0, 1, 0, 4'b0001));
    vecs.push_back(mk(1, 2'd0, 8'd2, 2'd1, 1, 0, 4'b0010));
    vecs.push_back(mk(1, 2'd0, 8'd2, 2'd1, 1, 0, 4'b0010));
    vecs.push_back(mk(1, 2'd0, 8'd2, 2'd1, 1, 0, 4'b0010));
    vecs.push_back(mk(1, 2'd0, 8'd2, 2'd2, 1, 0, 4'b0100));
    vecs.push_back(mk(1, 2'd0, 8'd2, 2'd2, 1, 0, 4'b0100));
    vecs.push_back(mk(1, 2'd0, 8'd2, 2'd2, 1, 0, 4'b0100));
    vecs.push_back(mk(1, 2'd0, 8'd2, 2'd3, 1, 0, 4'b1000));
    vecs.push_back(mk(1, 2'd0, 8'd2, 2'd3, 1, 0, 4'b1000));
    vecs.push_back(mk(1, 2'd0, 8'd2, 2'd3, 1, 0, 4'b1000));
    vecs.push_back(mk(1, 2'd0, 8'd2, 2'd0, 1, 1, 4'b0001));
    vecs.push_back(mk(1, 2'd0, 8'd2, 2'd0, 1, 0, 4'b0001));
    vecs.push_back(mk(0, 2'd0, 8'd2, 2'd0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 2'd1, 8'd0, 2'd0, 1, 0, 4'b0001));
    vecs.push_back(mk(1, 2'd1, 8'd0, 2'd3, 1, 1, 4'b1000));
    vecs.push_back(mk(1, 2'd1, 8'd0, 2'd2, 1, 0, 4'b0100));
    vecs.push_back(mk(1, 2'd1, 8'd0, 2'd1, 1, 0, 4'b0010));
    vecs.push_back(mk(1, 2'd1, 8'd0, 2'd0, 1, 0, 4'b0001));
    vecs.push_back(mk(0, 2'd1, 8'd0, 2'd0, 0, 0, 4'b0000));

    foreach (vecs[i]) begin
      en = vecs[i].en; mode = vecs[i].mode; dwell = vecs[i].dwell; req = vecs[i].req;
      step("tbl_model");
      chk($sformatf("tbl%0d.sel", i),   8'(sel),   8'(vecs[i].sel));
      chk($sformatf("tbl%0d.busy", i),  8'(busy),  8'(vecs[i].busy));
      chk($sformatf("tbl%0d.wrap", i),  8'(wrap),  8'(vecs[i].wrap));
      chk($sformatf("tbl%0d.ch_oh", i), 8'(ch_oh), 8'(vecs[i].ch_oh));
    end

    // Ping-pong, dwell=0, from sel=0
    pp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
    pp_wrp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    en = 1'b1; mode = 2'd2; dwell = 8'd0;
    for (int i = 0; i < 8; i++) begin
      step("pp_model");
      chk($sformatf("pp%0d.sel", i),  8'(sel),  8'(pp_sel[i]));
      chk($sformatf("pp%0d.wrap", i), 8'(wrap), 8'(pp_wrp[i]));
    end
    en = 1'b0;
    step("pp_stop");
    do_reset();

    // Round-robin, dwell=1, req 1010 then 0000 then 0001
    rr_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    rr_wrp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rr_req = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010,
               4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0001};
    en = 1'b1; mode = 2'd3; dwell = 8'd1;
    for (int i = 0; i < 13; i++) begin
      req = rr_req[i];
      step("rr_model");
      chk($sformatf("rr%0d.sel", i),  8'(sel),  8'(rr_sel[i]));
      chk($sformatf("rr%0d.wrap", i), 8'(wrap), 8'(rr_wrp[i]));
    end

    // Dwell shrinks from 10 to 1 while the counter sits at 5
    mode = 2'd0; dwell = 8'd10; req = 4'b0000;
    repeat (5) step("dw_model");
    chk("dwell_hold.sel", 8'(sel), 8'd0);
    dwell = 8'd1;
    step("dw_model");
    chk("dwell_shrink.sel", 8'(sel), 8'd1);

    // Enable dropped exactly on an advance edge
    step("endrop_model");
    en = 1'b0;
    step("endrop_model");
    chk("endrop.sel", 8'(sel), 8'd1);
    chk("endrop.busy", 8'(busy), 8'd0);
    chk("endrop.ch_oh", 8'(ch_oh), 8'd0);

    // Re-enable resumes from held sel with a fresh dwell count
    en = 1'b1; dwell = 8'd2;
    step("resume_model");
    chk("resume.sel", 8'(sel), 8'd1);
    chk("resume.ch_oh", 8'(ch_oh), 8'b0010);
    repeat (2) step("resume_model");
    chk("resume_hold.sel", 8'(sel), 8'd1);
    step("resume_model");
    chk("resume_adv.sel", 8'(sel), 8'd2);

    // Asynchronous reset pulse between clock edges
    step("areset_model");
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.sel", 8'(sel), 8'd0);
    chk("areset.busy", 8'(busy), 8'd0);
    chk("areset.ch_oh", 8'(ch_oh), 8'd0);
    chk("areset.wrap", 8'(wrap), 8'd0);
    model_reset();
    #2;
    rst_n = 1'b1;

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) dwell = 8'($urandom_range(0, 4));
      req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = 4'b0000;
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
